mmu_rx_cell2axis: RTL

// - Read side of the RC receive cell FIFO: pops 540-bit cells (data[511:0], mod[517:512], ERR[518], EOP[519], rsv[539:520])
//   and rebuilds a 512-bit AXI4-Stream towards user logic in the user_clk domain.
// - Restores tkeep from mod, flags errored packets on tuser, truncates runaway packets, keeps packet/error counters.

---
 rtl/mmu_rx_cell2axis_pkg.sv | 29 ++
 rtl/mmu_rx_cell2axis_if.sv | 14 +
 rtl/mmu_rx_cell2axis_buf2.sv | 59 +++++
 rtl/mmu_rx_cell2axis.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mmu_rx_cell2axis_pkg.sv
// Shared constants, beat record and FSM encoding for the RC receive cell-to-AXIS path.
package mmu_rx_pkg;

  localparam int CELL_W  = 540;
  localparam int EOP_POS = 519;
  localparam int ERR_POS = 518;
  localparam int MOD_LSB = 512;
  localparam int DATA_W  = 512;
  localparam int KEEP_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  // mod counts invalid trailing bytes; 0 means the whole beat is valid.
  function automatic logic [KEEP_W-1:0] mod2keep(input logic [5:0] mod);
    return {KEEP_W{1'b1}} >> mod;
  endfunction

endpackage

// File: rtl/mmu_rx_cell2axis_if.sv
// 512-bit AXI4-Stream bundle carrying rebuilt packets towards user logic.
interface mmu_rx_cell2axis_if;
  import mmu_rx_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/mmu_rx_cell2axis_buf2.sv
// Two-entry registered output buffer; entry 0 is always the head presented on the stream.
module mmu_rx_buf2
  import mmu_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  beat_t      din,
  output beat_t      dout,
  output logic [1:0] occ
);

  beat_t      e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d;

  // Pop always implies occ>=1 and the credit check upstream forbids push at occ==2 without pop.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = din;
        else               e1_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign dout = e0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/mmu_rx_cell2axis.sv
// Pops RC receive cells, rebuilds a 512-bit AXI4-Stream with tkeep/tuser, truncates runaway
// packets and keeps delivery/error/truncation counters.
module mmu_rx_cell2axis
  import mmu_rx_pkg::*;
#(
  parameter int MAX_BEATS = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  output logic              rc_rx_rd,
  input  logic [CELL_W-1:0] rc_rx_rdata,
  input  logic              rc_rx_ef,
  mmu_rx_cell2axis_if.master m_axis,
  input  logic              cnt_clr,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       err_cnt,
  output logic [31:0]       trunc_cnt
);

  localparam int BCW = $clog2(MAX_BEATS) + 1;

  rx_state_e      state_q, state_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           inflight_q;
  logic [31:0]    pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d, trunc_cnt_q, trunc_cnt_d;
  logic           push_s, pop_s, trunc_s, eop_s;
  logic [2:0]     credit_s;
  logic [1:0]     occ_s;
  beat_t          beat_s, head_s;

  mmu_rx_buf2 u_buf (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (beat_s),
    .dout  (head_s),
    .occ   (occ_s)
  );

  // A cell popped last cycle is still owed a slot even if it will be discarded.
  always_comb begin
    pop_s    = (occ_s != 2'd0) & m_axis.tready;
    credit_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    rc_rx_rd = ~rc_rx_ef & (credit_s < 3'd2);
  end

  // Classify the arriving cell and build the beat to buffer.
  always_comb begin
    eop_s       = rc_rx_rdata[EOP_POS];
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    push_s      = 1'b0;
    trunc_s     = 1'b0;
    beat_s.data = rc_rx_rdata[DATA_W-1:0];
    beat_s.keep = {KEEP_W{1'b1}};
    beat_s.last = 1'b0;
    beat_s.user = 1'b0;
    if (inflight_q) begin
      case (state_q)
        ST_IDLE, ST_BODY: begin
          push_s = 1'b1;
          if (eop_s) begin
            beat_s.keep = mod2keep(rc_rx_rdata[MOD_LSB+5:MOD_LSB]);
            beat_s.last = 1'b1;
            beat_s.user = rc_rx_rdata[ERR_POS];
            state_d     = ST_IDLE;
            beat_cnt_d  = '0;
          end else if (beat_cnt_q == BCW'(MAX_BEATS - 1)) begin
            beat_s.last = 1'b1;
            beat_s.user = 1'b1;
            trunc_s     = 1'b1;
            state_d     = ST_DISCARD;
            beat_cnt_d  = '0;
          end else begin
            state_d    = ST_BODY;
            beat_cnt_d = beat_cnt_q + BCW'(1);
          end
        end
        ST_DISCARD: begin
          if (eop_s) state_d = ST_IDLE;
          else       state_d = ST_DISCARD;
        end
        default: begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Clear takes priority over any increment landing in the same cycle.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (cnt_clr) begin
      pkt_cnt_d   = 32'd0;
      err_cnt_d   = 32'd0;
      trunc_cnt_d = 32'd0;
    end else begin
      if (pop_s && head_s.last) begin
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        if (head_s.user) err_cnt_d = err_cnt_q + 32'd1;
        else             err_cnt_d = err_cnt_q;
      end else begin
        pkt_cnt_d = pkt_cnt_q;
      end
      if (trunc_s) trunc_cnt_d = trunc_cnt_q + 32'd1;
      else         trunc_cnt_d = trunc_cnt_q;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      pkt_cnt_q   <= 32'd0;
      err_cnt_q   <= 32'd0;
      trunc_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= rc_rx_rd;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign m_axis.tdata  = head_s.data;
  assign m_axis.tkeep  = head_s.keep;
  assign m_axis.tlast  = head_s.last;
  assign m_axis.tuser  = head_s.user;
  assign m_axis.tvalid = (occ_s != 2'd0);
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign trunc_cnt     = trunc_cnt_q;

endmodule
